// File: rtl/dmem_arbiter.sv
// Single data-memory port arbiter between the core load/store path and a DMA/debug requester.
// Optional counters behind DMEM_ARB_STATS_EN: conflict_cnt and dma_pri_cnt.
module dmem_arbiter #(
    parameter int unsigned DM_ADDRESS   = 9,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [DM_ADDRESS-1:0] dma_addr,
    input  logic [DATA_W-1:0]     dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_W-1:0]     dma_rdata,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]           conflict_cnt,
    output logic [15:0]           dma_pri_cnt,
`endif
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_RD = 2'd1,
        DMA_RD  = 2'd2
    } state_t;

    state_t     fsm;
    state_t     fsm_next;
    logic [3:0] starve_cnt;
    logic       dma_pri;
    logic       dma_win;
    logic       core_win;

    // DMA takes the port when it has starved long enough or the core is not asking
    assign dma_pri  = dma_req && (starve_cnt == 4'(STARVE_LIMIT));
    assign dma_win  = dma_pri || (dma_req && !core_req);
    assign core_win = !dma_win && core_req;

    always_comb begin
        core_rdata = '0;
        core_stall = 1'b0;
        dma_gnt    = 1'b0;
        dma_rvalid = 1'b0;
        dma_rdata  = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fsm_next   = fsm;
        if (reset) begin
            core_stall = core_req;
            fsm_next   = IDLE;
        end else begin
            case (fsm)
                IDLE: begin
                    if (dma_win) begin
                        dma_gnt    = 1'b1;
                        mem_addr   = dma_addr;
                        core_stall = core_req;
                        if (dma_we) begin
                            mem_we    = 1'b1;
                            mem_wdata = dma_wdata;
                        end else begin
                            mem_re   = 1'b1;
                            fsm_next = DMA_RD;
                        end
                    end else if (core_win) begin
                        mem_addr = core_addr;
                        if (core_we) begin
                            mem_we    = 1'b1;
                            mem_wdata = core_wdata;
                        end else begin
                            mem_re     = 1'b1;
                            core_stall = 1'b1;
                            fsm_next   = CORE_RD;
                        end
                    end
                end
                CORE_RD: begin
                    core_rdata = mem_rdata;
                    fsm_next   = IDLE;
                end
                DMA_RD: begin
                    dma_rvalid = 1'b1;
                    dma_rdata  = mem_rdata;
                    core_stall = core_req;
                    fsm_next   = IDLE;
                end
                default: fsm_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm        <= IDLE;
            starve_cnt <= '0;
        end else begin
            fsm <= fsm_next;
            if (!dma_req || dma_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic conflict_hit;
    logic pri_hit;

    assign conflict_hit = !reset && (fsm == IDLE) && core_req && dma_req;
    assign pri_hit      = !reset && (fsm == IDLE) && dma_pri;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
            dma_pri_cnt  <= '0;
        end else begin
            if (conflict_hit && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (pri_hit && (dma_pri_cnt != '1)) begin
                dma_pri_cnt <= dma_pri_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed test-plan steps then randomized traffic against a transaction-level model.
// Stats counters are modelled and checked when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, dma_req, dma_we;
    logic [AW-1:0] core_addr, dma_addr, mem_addr;
    logic [DW-1:0] core_wdata, dma_wdata, core_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic          core_stall, dma_gnt, dma_rvalid, mem_re, mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   conflict_cnt, dma_pri_cnt;
    int            m_conflict, m_pri;
`endif

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_STATS_EN
        .conflict_cnt(conflict_cnt), .dma_pri_cnt(dma_pri_cnt),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // Memory behind the port: one-cycle registered read
    logic [DW-1:0] mem [512];
    bit            written [512];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if (mem_re) mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    end

    // Reference model: expected memory contents, outstanding read owner, DMA denial streak
    logic [DW-1:0] ref_mem [512];
    bit            ref_written [512];
    bit            core_waiting, dma_waiting;
    logic [AW-1:0] wait_addr;
    int            streak;
    logic          last_stall, last_gnt;

    logic [DW-1:0] o_core_rdata, o_dma_rdata;
    logic          o_stall, o_gnt, o_rvalid, o_re, o_we;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_written[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    task automatic step();
        logic          e_stall, e_gnt, e_rvalid, e_re, e_we, busy, dma_first;
        logic [DW-1:0] e_crd, e_drd, e_wd;
        logic [AW-1:0] e_addr;
        e_stall = 0; e_gnt = 0; e_rvalid = 0; e_re = 0; e_we = 0;
        e_crd = '0; e_drd = '0; e_wd = '0; e_addr = '0;
        busy = core_waiting || dma_waiting;
        dma_first = 0;
        @(negedge clk);
        if (reset) begin
            e_stall = core_req;
        end else if (core_waiting) begin
            e_crd = ref_read(wait_addr);
        end else if (dma_waiting) begin
            e_rvalid = 1; e_drd = ref_read(wait_addr); e_stall = core_req;
        end else begin
            dma_first = dma_req && (streak >= int'(LIMIT) || !core_req);
            if (dma_first) begin
                e_gnt = 1; e_addr = dma_addr; e_stall = core_req;
                e_we = dma_we; e_re = !dma_we; e_wd = dma_wdata;
            end else if (core_req) begin
                e_addr = core_addr; e_we = core_we; e_re = !core_we;
                e_wd = core_wdata; e_stall = !core_we;
            end
        end
        o_core_rdata = core_rdata; o_dma_rdata = dma_rdata;
        o_stall = core_stall; o_gnt = dma_gnt; o_rvalid = dma_rvalid; o_re = mem_re; o_we = mem_we;
        chk("core_stall", core_stall, e_stall);
        chk("core_rdata", core_rdata, e_crd);
        chk("dma_gnt", dma_gnt, e_gnt);
        chk("dma_rvalid", dma_rvalid, e_rvalid);
        chk("dma_rdata", dma_rdata, e_drd);
        chk("mem_re", mem_re, e_re);
        chk("mem_we", mem_we, e_we);
        if (e_re || e_we) chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
`ifdef DMEM_ARB_STATS_EN
        chk("conflict_cnt", conflict_cnt, m_conflict);
        chk("dma_pri_cnt", dma_pri_cnt, m_pri);
`endif
        @(posedge clk);
        if (reset) begin
            core_waiting = 0; dma_waiting = 0; streak = 0;
`ifdef DMEM_ARB_STATS_EN
            m_conflict = 0; m_pri = 0;
`endif
        end else begin
`ifdef DMEM_ARB_STATS_EN
            if (!busy && core_req && dma_req && m_conflict < 16'hFFFF) m_conflict++;
            if (e_gnt && streak >= int'(LIMIT) && m_pri < 16'hFFFF) m_pri++;
`endif
            core_waiting = 0; dma_waiting = 0;
            if (e_we) begin
                ref_mem[e_addr] = e_wd; ref_written[e_addr] = 1;
            end
            if (e_re) begin
                wait_addr = e_addr;
                if (e_gnt) dma_waiting = 1; else core_waiting = 1;
            end
            streak = (dma_req && !e_gnt) ? streak + 1 : 0;
        end
        last_stall = e_stall; last_gnt = e_gnt;
        #1;
    endtask

    initial begin
        core_waiting = 0; dma_waiting = 0; streak = 0; wait_addr = '0;
        last_stall = 0; last_gnt = 0;
`ifdef DMEM_ARB_STATS_EN
        m_conflict = 0; m_pri = 0;
`endif
        reset = 1;
        set_core(1, 0, 9'h000, '0);
        set_dma(0, 0, 9'h000, '0);
        step();
        chk("reset_stall", o_stall, 1);
        set_core(0, 0, 9'h000, '0);
        step();
        chk("reset_stall_idle", o_stall, 0);
        reset = 0;

        // Core store, then load it back
        set_core(1, 1, 9'h010, 32'hDEADBEEF);
        step();
        chk("store_we", o_we, 1);
        chk("store_stall", o_stall, 0);
        set_core(1, 0, 9'h010, '0);
        step();
        chk("load_c0_stall", o_stall, 1);
        step();
        chk("load_c1_stall", o_stall, 0);
        chk("load_c1_data", o_core_rdata, 32'hDEADBEEF);
        set_core(0, 0, 9'h000, '0);

        // DMA preload then DMA read
        set_dma(1, 1, 9'h020, 32'h12345678);
        step();
        set_dma(1, 0, 9'h020, '0);
        step();
        chk("dma_rd_gnt", o_gnt, 1);
        set_dma(0, 0, 9'h000, '0);
        step();
        chk("dma_rd_valid", o_rvalid, 1);
        chk("dma_rd_data", o_dma_rdata, 32'h12345678);

        // Starvation: back-to-back core stores with DMA waiting
        set_dma(1, 1, 9'h030, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            set_core(1, 1, 9'(9'h100 + i), 32'(i) + 32'h1000);
            step();
            chk("starve_gnt", o_gnt, (i == 4) ? 1 : 0);
        end
        chk("starve_stall", o_stall, 1);
        set_dma(0, 0, 9'h000, '0);
        step();
        chk("starve_cnt_clr", dut.starve_cnt, 0);
        chk("starve_core_done", o_stall, 0);

        // Contention: core load against DMA write
        set_core(1, 0, 9'h010, '0);
        set_dma(1, 1, 9'h040, 32'hA5A55A5A);
        step();
        chk("cont_c0_re", o_re, 1);
        chk("cont_c0_gnt", o_gnt, 0);
        step();
        chk("cont_c1_data", o_core_rdata, 32'hDEADBEEF);
        set_core(0, 0, 9'h000, '0);
        step();
        chk("cont_c2_gnt", o_gnt, 1);
        set_dma(0, 0, 9'h000, '0);
        set_core(1, 0, 9'h040, '0);
        step();
        step();
        chk("cont_verify", o_core_rdata, 32'hA5A55A5A);
        set_core(0, 0, 9'h000, '0);

        // Reset while a core read is outstanding
        set_core(1, 0, 9'h010, '0);
        step();
        reset = 1;
        step();
        chk("rst_rd_data", o_core_rdata, 0);
        reset = 0;
        set_core(0, 0, 9'h000, '0);
        step();
        chk("rst_rd_after", o_core_rdata, 0);
        chk("rst_rd_rvalid", o_rvalid, 0);
        set_core(1, 0, 9'h010, '0);
        step();
        step();
        chk("rst_reload", o_core_rdata, 32'hDEADBEEF);
        set_core(0, 0, 9'h000, '0);

        // Randomized traffic honouring the hold rules
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(63) == 0);
            if (!(core_req && last_stall)) begin
                set_core(($urandom_range(3) != 0), 1'($urandom), 9'($urandom_range(31)), $urandom);
            end
            if (!(dma_req && !last_gnt)) begin
                set_dma(($urandom_range(2) == 0), 1'($urandom), 9'($urandom_range(31)), $urandom);
            end
            step();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Owns the single data-memory port and shares it between the core datapath (load/store path) and a DMA/debug requester.
- Stalls the core whenever the core cannot complete its access in the current cycle.
- Sits between the datapath's load/store signals and mem_data.
- Memory read data is returned one cycle after mem_re.

Parameters:
DM_ADDRESS, 9, data-memory address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA gets priority (legal range 1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
core_req  in  1  core memory access request (MemRead or MemWrite); held stable while core_stall=1
core_we  in  1  1=store, 0=load
core_addr  in  DM_ADDRESS  core byte address
core_wdata  in  DATA_W  core store data
core_rdata  out  DATA_W  load data to core; valid in the cycle core_stall drops after a read
core_stall  out  1  freeze PC/regfile write this cycle
dma_req  in  1  DMA request; held stable until dma_gnt=1
dma_we  in  1  1=write, 0=read
dma_addr  in  DM_ADDRESS  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access issued this cycle
dma_rvalid  out  1  DMA read data valid (1 cycle after read grant)
dma_rdata  out  DATA_W  DMA read data
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_addr  out  DM_ADDRESS  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_re

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Registered state: fsm, starve_cnt (4 bits).
- Reset: fsm=IDLE, starve_cnt=0.
- Reset outputs: core_stall=core_req, all other outputs 0.
- All outputs are combinational from fsm, starve_cnt and the request inputs.
- FSM states: IDLE, CORE_RD, DMA_RD.
- IDLE, arbitration:
  - dma_pri = dma_req && (starve_cnt == STARVE_LIMIT).
  - Winner is DMA if dma_pri, or if dma_req && !core_req; otherwise core if core_req; otherwise none.
- IDLE, core wins:
  - mem_addr=core_addr.
  - Write: mem_we=1, mem_wdata=core_wdata, core_stall=0; stay IDLE.
  - Read: mem_re=1, core_stall=1; go to CORE_RD.
- IDLE, DMA wins:
  - dma_gnt=1, mem_addr=dma_addr.
  - Write: mem_we=1; stay IDLE.
  - Read: mem_re=1; go to DMA_RD.
  - If core_req=1 in the same cycle: core_stall=1.
- CORE_RD:
  - core_rdata=mem_rdata, core_stall=0.
  - No new memory access is issued; go to IDLE.
  - Core load latency is 2 cycles.
- DMA_RD:
  - dma_rvalid=1, dma_rdata=mem_rdata, no new access; go to IDLE.
  - core_stall=core_req.
- core_rdata and dma_rdata are 0 outside their valid cycle.
- starve_cnt:
  - Clears on dma_gnt or when dma_req=0.
  - Otherwise increments in every cycle dma_req=1 && dma_gnt=0, including CORE_RD and DMA_RD cycles.
  - Saturates at STARVE_LIMIT.
- Write latency is 0 extra cycles: a store completes in the grant cycle.
- mem_re and mem_we are never both 1. At most one of core/DMA is served per cycle.
- Reset mid-read (CORE_RD or DMA_RD): the access is abandoned; no rvalid and no core data are returned after reset.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: the core wins; the DMA waits.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - Adds output conflict_cnt [15:0], a count of cycles with core_req && dma_req both 1 in IDLE. It saturates at 16'hFFFF and clears on reset.
  - Adds output dma_pri_cnt [15:0], a count of grants won via dma_pri. It saturates and clears on reset.
- When undefined: neither port nor its counter logic exists; behaviour is otherwise identical.

Test Plan:
- Core store only: core_req=1, we=1, addr=0x010, wdata=0xDEADBEEF → mem_we=1, addr 0x010 in the same cycle, core_stall=0; a later load of 0x010 returns 0xDEADBEEF.
- Core load: core_req=1, we=0, addr=0x010 → cycle0 mem_re=1, core_stall=1; cycle1 core_stall=0, core_rdata=0xDEADBEEF.
- DMA read only: dma_req=1, we=0, addr=0x020 (holding 0x12345678) → dma_gnt=1 in cycle0; dma_rvalid=1, dma_rdata=0x12345678 in cycle1.
- Starvation: STARVE_LIMIT=4, core issues back-to-back stores with dma_req=1 → DMA denied 4 cycles, granted in the 5th; core_stall=1 in that cycle; starve_cnt returns to 0.
- Contention on read: core load and DMA write (both request) with starve_cnt=0 → core served (2 cycles), DMA granted in cycle2; written data is verified by a follow-up core load.
- Reset during CORE_RD: assert reset for 1 cycle → fsm=IDLE, core_rdata=0, no dma_rvalid; a subsequent load behaves normally.
